// File: rtl/disp_ctrl_multi.sv
// disp_ctrl_multi: hex debug overlay for the VGA path.
// Shows NUM_ROWS channels as hex text rows. All channels are sampled together
// at frame start. Digits that changed at a snapshot are drawn in CHG_COLOR
// for HOLD_FRAMES frames. Glyphs come from an external synchronous 256x8 ROM.
module disp_ctrl_multi #(
    parameter int unsigned NUM_ROWS    = 6,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FIRST_LINE  = 2,
    parameter int unsigned FIRST_COL   = 4,
    parameter int unsigned HOLD_FRAMES = 3,
    parameter logic [23:0] FG_COLOR    = 24'hFFFFFF,
    parameter logic [23:0] CHG_COLOR   = 24'hFFFF00
) (
    input  logic                       vga_clk,
    input  logic                       rst_n,
    input  logic [NUM_ROWS*DATA_W-1:0] data_in,
    input  logic                       frame_start,
    input  logic                       freeze,
    input  logic                       de,
    input  logic [9:1]                 x_pos,
    input  logic [9:1]                 y_pos,
    output logic [7:0]                 rom_addr,
    input  logic [7:0]                 rom_dout,
    output logic [7:0]                 red,
    output logic [7:0]                 green,
    output logic [7:0]                 blue
);

    localparam int unsigned ND = DATA_W / 4;

    // Elaboration-time legality checks
    if (NUM_ROWS < 1 || NUM_ROWS > 16) begin : g_bad_rows
        $error("disp_ctrl_multi: NUM_ROWS must be 1..16");
    end
    if (DATA_W == 0 || (DATA_W % 4) != 0) begin : g_bad_width
        $error("disp_ctrl_multi: DATA_W must be a non-zero multiple of 4");
    end
    if (FIRST_LINE + NUM_ROWS > 32) begin : g_bad_lines
        $error("disp_ctrl_multi: FIRST_LINE+NUM_ROWS exceeds 32");
    end
    if (FIRST_COL + ND > 64) begin : g_bad_cols
        $error("disp_ctrl_multi: FIRST_COL+ND exceeds 64");
    end
    if (HOLD_FRAMES > 15) begin : g_bad_hold
        $error("disp_ctrl_multi: HOLD_FRAMES must be 0..15");
    end

    // Snapshot state
    logic [DATA_W-1:0] snap_q [NUM_ROWS];
    logic [DATA_W-1:0] snap_d [NUM_ROWS];
    logic [ND-1:0]     chg_q  [NUM_ROWS];
    logic [ND-1:0]     chg_d  [NUM_ROWS];
    logic [3:0]        age_q  [NUM_ROWS];
    logic [3:0]        age_d  [NUM_ROWS];
    logic [ND-1:0]     diff;

    // S1 lookup
    logic [5:0]        row_off;
    logic [7:0]        col_off;
    logic              row_hit;
    logic              col_hit;
    logic              cell_hit;
    logic [DATA_W-1:0] row_data;
    logic [ND-1:0]     row_chg;
    logic [3:0]        nib;
    logic              nib_chg;

    // Pipeline registers
    logic       s1_hit_d,  s1_hit_q;
    logic       s1_chg_d,  s1_chg_q;
    logic [2:0] s1_gcol_d, s1_gcol_q;
    logic       s1_de_d,   s1_de_q;
    logic [7:0] rom_addr_d, rom_addr_q;
    logic       s2_hit_d,  s2_hit_q;
    logic       s2_chg_d,  s2_chg_q;
    logic [2:0] s2_gcol_d, s2_gcol_q;
    logic       s2_de_d,   s2_de_q;
    logic [23:0] rgb_d,    rgb_q;

    // Snapshot update: capture channels, mark changed digits, age highlights
    always_comb begin
        diff = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            snap_d[r] = snap_q[r];
            chg_d[r]  = chg_q[r];
            age_d[r]  = age_q[r];
        end
        if (frame_start && !freeze) begin
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                diff = '0;
                for (int unsigned d = 0; d < ND; d++) begin
                    diff[d] = data_in[r*DATA_W + 4*(ND-1-d) +: 4] != snap_q[r][4*(ND-1-d) +: 4];
                end
                snap_d[r] = data_in[r*DATA_W +: DATA_W];
                if (diff != '0) begin
                    chg_d[r] = (HOLD_FRAMES == 0) ? '0 : diff;
                    age_d[r] = 4'(HOLD_FRAMES);
                end else if (age_q[r] != 4'd0) begin
                    age_d[r] = age_q[r] - 4'd1;
                    if (age_q[r] == 4'd1) begin
                        chg_d[r] = '0;
                    end
                end
            end
        end
    end

    // Snapshot state registers
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                snap_q[r] <= '0;
                chg_q[r]  <= '0;
                age_q[r]  <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                snap_q[r] <= snap_d[r];
                chg_q[r]  <= chg_d[r];
                age_q[r]  <= age_d[r];
            end
        end
    end

    // S1: locate the cell in the text grid and fetch its nibble and highlight bit.
    // Offsets are unsigned, so a position left of/above the grid wraps to a large
    // value and fails the single upper-bound compare.
    always_comb begin
        row_off  = {1'b0, y_pos[9:5]} - 6'(FIRST_LINE);
        col_off  = {2'b00, x_pos[9:4]} - 8'(FIRST_COL);
        row_hit  = row_off < 6'(NUM_ROWS);
        col_hit  = col_off < 8'(ND);
        cell_hit = row_hit && col_hit;
        row_data = '0;
        row_chg  = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (row_off == 6'(r)) begin
                row_data = snap_q[r];
                row_chg  = chg_q[r];
            end
        end
        nib     = '0;
        nib_chg = 1'b0;
        for (int unsigned d = 0; d < ND; d++) begin
            if (cell_hit && col_off == 8'(d)) begin
                nib     = row_data[4*(ND-1-d) +: 4];
                nib_chg = row_chg[d];
            end
        end
        s1_hit_d   = cell_hit;
        s1_chg_d   = nib_chg;
        s1_gcol_d  = x_pos[3:1];
        s1_de_d    = de;
        rom_addr_d = {nib, y_pos[4:1]};
    end

    // S2 and S3: carry cell attributes alongside the ROM read, then colour the pixel
    always_comb begin
        s2_hit_d  = s1_hit_q;
        s2_chg_d  = s1_chg_q;
        s2_gcol_d = s1_gcol_q;
        s2_de_d   = s1_de_q;
        rgb_d     = '0;
        if (s2_de_q && s2_hit_q && rom_dout[3'd7 - s2_gcol_q]) begin
            rgb_d = s2_chg_q ? CHG_COLOR : FG_COLOR;
        end
    end

    // Pixel pipeline registers
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit_q   <= 1'b0;
            s1_chg_q   <= 1'b0;
            s1_gcol_q  <= '0;
            s1_de_q    <= 1'b0;
            rom_addr_q <= '0;
            s2_hit_q   <= 1'b0;
            s2_chg_q   <= 1'b0;
            s2_gcol_q  <= '0;
            s2_de_q    <= 1'b0;
            rgb_q      <= '0;
        end else begin
            s1_hit_q   <= s1_hit_d;
            s1_chg_q   <= s1_chg_d;
            s1_gcol_q  <= s1_gcol_d;
            s1_de_q    <= s1_de_d;
            rom_addr_q <= rom_addr_d;
            s2_hit_q   <= s2_hit_d;
            s2_chg_q   <= s2_chg_d;
            s2_gcol_q  <= s2_gcol_d;
            s2_de_q    <= s2_de_d;
            rgb_q      <= rgb_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign red      = rgb_q[23:16];
    assign green    = rgb_q[15:8];
    assign blue     = rgb_q[7:0];

endmodule

// File: tb/tb_disp_ctrl_multi.sv
// Testbench for disp_ctrl_multi: two configurations driven in parallel
// (6x32-bit at column 4, 16x16-bit at column 0), checked against a
// behavioural screen model through per-output scoreboards.
module tb_disp_ctrl_multi;

    localparam logic [23:0] WHITE  = 24'hFFFFFF;
    localparam logic [23:0] YELLOW = 24'hFFFF00;
    localparam int FL   = 2;
    localparam int HOLD = 3;

    logic vga_clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0, freeze = 1'b0, de = 1'b0;
    logic [9:1] x_pos = '0, y_pos = '0;
    logic [6*32-1:0]  data0 = '0;
    logic [16*16-1:0] data1 = '0;
    logic [7:0] rom_addr0, rom_dout0, red0, green0, blue0;
    logic [7:0] rom_addr1, rom_dout1, red1, green1, blue1;
    logic [7:0] glyph [256];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int crows [2] = '{6, 16};
    int cdw   [2] = '{32, 16};
    int cfc   [2] = '{4, 0};

    logic [31:0] mdata [2][16];
    logic [31:0] msnap [2][16];
    logic [7:0]  mchg  [2][16];
    int          mage  [2][16];

    typedef struct {
        int          due;
        logic [23:0] v;
    } ent_t;
    ent_t qr0[$], qr1[$], qa0[$], qa1[$];

    disp_ctrl_multi #(
        .NUM_ROWS(6), .DATA_W(32), .FIRST_LINE(2), .FIRST_COL(4),
        .HOLD_FRAMES(3), .FG_COLOR(24'hFFFFFF), .CHG_COLOR(24'hFFFF00)
    ) u_dut0 (
        .vga_clk(vga_clk), .rst_n(rst_n), .data_in(data0),
        .frame_start(frame_start), .freeze(freeze), .de(de),
        .x_pos(x_pos), .y_pos(y_pos), .rom_addr(rom_addr0), .rom_dout(rom_dout0),
        .red(red0), .green(green0), .blue(blue0)
    );

    disp_ctrl_multi #(
        .NUM_ROWS(16), .DATA_W(16), .FIRST_LINE(2), .FIRST_COL(0),
        .HOLD_FRAMES(3), .FG_COLOR(24'hFFFFFF), .CHG_COLOR(24'hFFFF00)
    ) u_dut1 (
        .vga_clk(vga_clk), .rst_n(rst_n), .data_in(data1),
        .frame_start(frame_start), .freeze(freeze), .de(de),
        .x_pos(x_pos), .y_pos(y_pos), .rom_addr(rom_addr1), .rom_dout(rom_dout1),
        .red(red1), .green(green1), .blue(blue1)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) cyc <= cyc + 1;

    // Synchronous glyph ROMs
    always @(posedge vga_clk) begin
        rom_dout0 <= glyph[rom_addr0];
        rom_dout1 <= glyph[rom_addr1];
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endfunction

    // Monitor: compare each output against the entry due in this cycle
    always @(negedge vga_clk) begin
        ent_t e;
        if (rst_n) begin
            while (qr0.size() > 0 && qr0[0].due <= cyc) begin
                e = qr0.pop_front();
                chk("rgb_cfg0", {8'h0, red0, green0, blue0}, {8'h0, e.v});
            end
            while (qa0.size() > 0 && qa0[0].due <= cyc) begin
                e = qa0.pop_front();
                chk("rom_addr_cfg0", {24'h0, rom_addr0}, {8'h0, e.v});
            end
            while (qr1.size() > 0 && qr1[0].due <= cyc) begin
                e = qr1.pop_front();
                chk("rgb_cfg1", {8'h0, red1, green1, blue1}, {8'h0, e.v});
            end
            while (qa1.size() > 0 && qa1[0].due <= cyc) begin
                e = qa1.pop_front();
                chk("rom_addr_cfg1", {24'h0, rom_addr1}, {8'h0, e.v});
            end
        end
    end

    // Screen model: what a pixel at (x, y) must look like given the snapshot state
    function automatic void model_pix(input int c, input bit d, input int x, input int y,
                                      output logic [23:0] rgb, output logic [7:0] addr);
        int line = y / 16;
        int grow = y % 16;
        int col  = x / 8;
        int gcol = x % 8;
        int nd   = cdw[c] / 4;
        int nibv = 0;
        bit hl   = 1'b0;
        bit hit;
        hit = line >= FL && line < FL + crows[c] && col >= cfc[c] && col < cfc[c] + nd;
        if (hit) begin
            nibv = int'((msnap[c][line-FL] >> (cdw[c] - 4 - 4*(col-cfc[c]))) & 32'hF);
            hl   = mchg[c][line-FL][col-cfc[c]];
        end
        addr = 8'(nibv * 16 + grow);
        rgb  = (d && hit && glyph[addr][7-gcol]) ? (hl ? YELLOW : WHITE) : 24'h0;
    endfunction

    function automatic void model_snap(input int c);
        int nd = cdw[c] / 4;
        for (int r = 0; r < crows[c]; r++) begin
            logic [31:0] nv;
            logic [7:0]  dmask;
            nv = (cdw[c] == 32) ? mdata[c][r] : (mdata[c][r] & ((32'd1 << cdw[c]) - 1));
            dmask = '0;
            for (int d = 0; d < nd; d++) begin
                if (((nv >> (cdw[c]-4-4*d)) & 32'hF) != ((msnap[c][r] >> (cdw[c]-4-4*d)) & 32'hF))
                    dmask[d] = 1'b1;
            end
            msnap[c][r] = nv;
            if (dmask != 0) begin
                mchg[c][r] = dmask;
                mage[c][r] = HOLD;
            end else if (mage[c][r] > 0) begin
                mage[c][r]--;
                if (mage[c][r] == 0) mchg[c][r] = '0;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 16; r++) begin
                msnap[c][r] = '0;
                mchg[c][r]  = '0;
                mage[c][r]  = 0;
            end
    endfunction

    task automatic apply_data();
        for (int r = 0; r < 6; r++)  data0[r*32 +: 32] = mdata[0][r];
        for (int r = 0; r < 16; r++) data1[r*16 +: 16] = mdata[1][r][15:0];
    endtask

    task automatic set_row(input int r, input logic [31:0] v0, input logic [15:0] v1);
        mdata[0][r] = v0;
        mdata[1][r] = {16'h0, v1};
        apply_data();
    endtask

    // One pixel clock of stimulus; expectations are queued before the edge
    task automatic step(input bit fs, input bit frz, input bit d, input int x, input int y);
        logic [23:0] rgb;
        logic [7:0]  addr;
        frame_start = fs;
        freeze      = frz;
        de          = d;
        x_pos       = 9'(x);
        y_pos       = 9'(y);
        model_pix(0, d, x, y, rgb, addr);
        qr0.push_back('{cyc + 3, rgb});
        qa0.push_back('{cyc + 1, 24'(addr)});
        model_pix(1, d, x, y, rgb, addr);
        qr1.push_back('{cyc + 3, rgb});
        qa1.push_back('{cyc + 1, 24'(addr)});
        if (fs && !frz) begin
            model_snap(0);
            model_snap(1);
        end
        @(posedge vga_clk);
        #1;
    endtask

    task automatic frame(input bit frz);
        step(1'b1, frz, 1'b0, 0, 0);
    endtask

    task automatic scan(input int line, input int ng, input int xmax);
        for (int g = 0; g < ng; g++) begin
            int grow = $urandom_range(0, 15);
            for (int x = 0; x < xmax; x++) step(1'b0, 1'b0, 1'b1, x, line*16 + grow);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rgb0"}, {8'h0, red0, green0, blue0}, 32'h0);
        chk({tag, "_rgb1"}, {8'h0, red1, green1, blue1}, 32'h0);
        chk({tag, "_addr0"}, {24'h0, rom_addr0}, 32'h0);
        chk({tag, "_addr1"}, {24'h0, rom_addr1}, 32'h0);
    endtask

    // The pipeline is empty after release: two black cycles before the first pixel lands
    task automatic release_reset();
        rst_n = 1'b1;
        qr0.push_back('{cyc + 1, 24'h0});
        qr0.push_back('{cyc + 2, 24'h0});
        qr1.push_back('{cyc + 1, 24'h0});
        qr1.push_back('{cyc + 2, 24'h0});
    endtask

    task automatic mutate();
        for (int c = 0; c < 2; c++) begin
            int r = $urandom_range(0, crows[c] - 1);
            int k = $urandom_range(0, cdw[c]/4 - 1);
            mdata[c][r] = mdata[c][r] ^ (32'($urandom_range(1, 15)) << (4*k));
        end
        apply_data();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) glyph[i] = 8'($urandom) | 8'h01;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 16; r++) mdata[c][r] = '0;
        model_reset();
        apply_data();

        // Reset state
        repeat (2) @(posedge vga_clk);
        #1;
        check_zero("reset");
        release_reset();

        // Basic render: zeros before the first snapshot, then row 0
        scan(2, 1, 128);
        set_row(0, 32'h1234ABCD, 16'h12AB);
        frame(1'b0);
        scan(2, 3, 128);

        // Single-cycle de inside a digit cell
        for (int x = 32; x < 48; x++) step(1'b0, 1'b0, (x == 37), x, 2*16 + 5);
        for (int x = 0; x < 16; x++) step(1'b0, 1'b0, (x == 2), x, 3*16 + 9);

        // Change highlight: one change frame then three quiet frames
        set_row(1, 32'h000000F0, 16'h00F0);
        frame(1'b0);
        scan(3, 2, 128);
        for (int f = 0; f < 3; f++) begin
            frame(1'b0);
            scan(3, 2, 128);
        end

        // Re-change during hold
        set_row(1, 32'h000F00F0, 16'h0FF0);
        frame(1'b0);
        scan(3, 1, 128);
        frame(1'b0);
        set_row(1, 32'hF00F00F0, 16'hFFF0);
        frame(1'b0);
        scan(3, 2, 128);
        frame(1'b0);
        scan(3, 1, 128);

        // Freeze: data changes are held off, diff taken against the pre-freeze snapshot
        set_row(2, 32'hCAFE0001, 16'hBEEF);
        set_row(1, 32'hF00F00F1, 16'hFFF1);
        frame(1'b1);
        scan(3, 1, 128);
        scan(4, 1, 128);
        frame(1'b1);
        scan(4, 1, 128);
        frame(1'b0);
        scan(3, 1, 128);
        scan(4, 2, 128);

        // Back-to-back snapshots, the second coinciding with active pixels
        set_row(0, 32'h89ABCDEF, 16'h4567);
        step(1'b1, 1'b0, 1'b1, 40, 2*16 + 3);
        set_row(0, 32'h89ABCDE0, 16'h4560);
        step(1'b1, 1'b0, 1'b1, 41, 2*16 + 3);
        scan(2, 2, 128);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 79) == 0) mutate();
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) != 0),
                 $urandom_range(0, 127), $urandom_range(0, 20*16 - 1));
        end

        // Asynchronous reset mid-line
        for (int x = 0; x < 40; x++) step(1'b0, 1'b0, 1'b1, x, 2*16 + 7);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        qr0.delete();
        qa0.delete();
        qr1.delete();
        qa1.delete();
        model_reset();
        repeat (3) begin
            @(posedge vga_clk);
            #1;
        end
        release_reset();
        for (int line = 2; line < 18; line++) scan(line, 1, 64);
        frame(1'b0);
        for (int line = 2; line < 18; line++) scan(line, 1, 64);

        // Drain and confirm every expectation was consumed
        de = 1'b0;
        frame_start = 1'b0;
        repeat (5) @(posedge vga_clk);
        #1;
        chk("drain", 32'(qr0.size() + qr1.size() + qa0.size() + qa1.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
